// File: rtl/sub_borrow_64bit_pipe.sv
// sub_borrow_64bit_pipe
// Pipelined 64-bit subtractor: Diff = A - B - Bin (mod 2^64), Borrow = borrow-out.
// An input register (p0) captures the operands. Four slice stages (p1..p4) each
// subtract 16 bits and ripple the borrow forward, so a result appears four edges
// after the operands were captured. A single global advance moves every stage
// together, so bubbles are kept rather than collapsed.
// Optional feature macro: SUB_FLAGS_EN adds the registered Zero and Overflow flags.
`timescale 1ns/1ps
module sub_borrow_64bit_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] A,
   input  logic [63:0] B,
   input  logic        Bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] Diff,
   output logic        Borrow
`ifdef SUB_FLAGS_EN
   ,
   output logic        Zero,
   output logic        Overflow
`endif
);

   // 17-bit slice subtract; bit 16 of the result is the slice borrow-out.
   function automatic logic [16:0] sub_slice(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic        bin);
      return {1'b0, a} - {1'b0, b} - {16'd0, bin};
   endfunction

   logic        adv;

   logic        vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;

   logic [63:0] a_p0_q, b_p0_q;
   logic        bin_p0_q;

   logic [15:0] diff_p1_q;
   logic [47:0] a_p1_q, b_p1_q;
   logic        brw_p1_q;

   logic [31:0] diff_p2_q;
   logic [31:0] a_p2_q, b_p2_q;
   logic        brw_p2_q;

   logic [47:0] diff_p3_q;
   logic [15:0] a_p3_q, b_p3_q;
   logic        brw_p3_q;

   logic [63:0] diff_p4_q;
   logic        brw_p4_q;

   logic [16:0] s0_d, s1_d, s2_d, s3_d;
   logic [63:0] diff_p4_d;

   // Every stage moves when the output slot is empty or being drained.
   assign adv      = !vld_p4_q || out_ready;
   assign in_ready = adv;

   assign s0_d      = sub_slice(a_p0_q[15:0], b_p0_q[15:0], bin_p0_q);
   assign s1_d      = sub_slice(a_p1_q[15:0], b_p1_q[15:0], brw_p1_q);
   assign s2_d      = sub_slice(a_p2_q[15:0], b_p2_q[15:0], brw_p2_q);
   assign s3_d      = sub_slice(a_p3_q, b_p3_q, brw_p3_q);
   assign diff_p4_d = {s3_d[15:0], diff_p3_q};

   assign out_valid = vld_p4_q;
   assign Diff      = diff_p4_q;
   assign Borrow    = brw_p4_q;

   // Valid chain: cleared by reset so in-flight operations are discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         vld_p4_q <= 1'b0;
      end else if (adv) begin
         vld_p0_q <= in_valid;
         vld_p1_q <= vld_p0_q;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         vld_p4_q <= vld_p3_q;
      end
   end

   // Internal data stages: no reset, their meaning is gated by the valid chain.
   always_ff @(posedge clk) begin
      if (adv) begin
         // p0: raw operands
         a_p0_q    <= A;
         b_p0_q    <= B;
         bin_p0_q  <= Bin;
         // p1: slice 0 done, upper 48 bits pending
         diff_p1_q <= s0_d[15:0];
         a_p1_q    <= a_p0_q[63:16];
         b_p1_q    <= b_p0_q[63:16];
         brw_p1_q  <= s0_d[16];
         // p2: slices 0..1 done
         diff_p2_q <= {s1_d[15:0], diff_p1_q};
         a_p2_q    <= a_p1_q[47:16];
         b_p2_q    <= b_p1_q[47:16];
         brw_p2_q  <= s1_d[16];
         // p3: slices 0..2 done, top slice (with sign bits) pending
         diff_p3_q <= {s2_d[15:0], diff_p2_q};
         a_p3_q    <= a_p2_q[31:16];
         b_p3_q    <= b_p2_q[31:16];
         brw_p3_q  <= s2_d[16];
      end
   end

   // Output stage: reset to zero, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_p4_q <= 64'd0;
         brw_p4_q  <= 1'b0;
      end else if (adv) begin
         diff_p4_q <= diff_p4_d;
         brw_p4_q  <= s3_d[16];
      end
   end

`ifdef SUB_FLAGS_EN
   logic zero_p4_q, ovf_p4_q;
   logic zero_d, ovf_d;

   assign zero_d   = (diff_p4_d == 64'd0);
   assign ovf_d    = (a_p3_q[15] != b_p3_q[15]) && (s3_d[15] != a_p3_q[15]);
   assign Zero     = zero_p4_q;
   assign Overflow = ovf_p4_q;

   // Flags registered alongside Diff, from the final difference and operand signs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_p4_q <= 1'b0;
         ovf_p4_q  <= 1'b0;
      end else if (adv) begin
         zero_p4_q <= zero_d;
         ovf_p4_q  <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_sub_borrow_64bit_pipe.sv
// Testbench for sub_borrow_64bit_pipe: directed cases, random streaming with
// back-pressure, bubbles and mid-flight reset, checked against a reference model.
`timescale 1ns/1ps
module tb_sub_borrow_64bit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] A, B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] Diff;
   logic        Borrow;
`ifdef SUB_FLAGS_EN
   logic        Zero, Overflow;
`endif

   int total = 0;
   int bad   = 0;
   int npop  = 0;

   typedef struct {
      logic [63:0] diff;
      logic        borrow;
      logic        zero;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];

   sub_borrow_64bit_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Borrow    (Borrow)
`ifdef SUB_FLAGS_EN
      ,
      .Zero      (Zero),
      .Overflow  (Overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on whole operands.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
      exp_t e;
      e.diff   = a - b - {63'd0, bi};
      e.borrow = ({1'b0, a} < ({1'b0, b} + {64'd0, bi}));
      e.zero   = (e.diff == 64'd0);
      e.ovf    = (a[63] != b[63]) && (e.diff[63] != a[63]);
      return e;
   endfunction

   // Scoreboard: record accepted operations, compare every delivered result in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            npop++;
            if (sb_q.size() == 0) begin
               chk("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_diff", Diff, e.diff);
               chk("sb_borrow", {63'd0, Borrow}, {63'd0, e.borrow});
`ifdef SUB_FLAGS_EN
               chk("sb_zero", {63'd0, Zero}, {63'd0, e.zero});
               chk("sb_ovf", {63'd0, Overflow}, {63'd0, e.ovf});
`endif
            end
         end
         if (in_valid && in_ready) sb_q.push_back(model(A, B, Bin));
      end
   end

   // Issue one operation, then count edges after the capturing edge until out_valid.
   task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic bi,
                          output int lat);
      A = a; B = b; Bin = bi; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int          lat;
      int          k;
      int          base;
      logic        acc;
      logic [63:0] hd;
      logic        hb;
      logic [63:0] sa[8];
      logic [63:0] sbv[8];
      logic        sbin[8];
      int          pat[5];
      logic        ov[12];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Bin = 1'b0;
      hd = '0; hb = 1'b0; acc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_diff", Diff, 64'd0);
      chk("rst_borrow", {63'd0, Borrow}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef SUB_FLAGS_EN
      chk("rst_zero", {63'd0, Zero}, 64'd0);
      chk("rst_ovf", {63'd0, Overflow}, 64'd0);
`endif
      rst_n = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("rdy_empty_out", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_one(64'd10, 64'd3, 1'b0, lat);
      chk("basic_lat", lat, 4);
      chk("basic_diff", Diff, 64'd7);
      chk("basic_borrow", {63'd0, Borrow}, 64'd0);
`ifdef SUB_FLAGS_EN
      chk("basic_zero", {63'd0, Zero}, 64'd0);
      chk("basic_ovf", {63'd0, Overflow}, 64'd0);
`endif
      run_one(64'd0, 64'd0, 1'b1, lat);
      chk("ripple_diff", Diff, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("ripple_borrow", {63'd0, Borrow}, 64'd1);

      run_one(64'h0001_0000_0000_0000, 64'd1, 1'b0, lat);
      chk("b48_diff", Diff, 64'h0000_FFFF_FFFF_FFFF);
      chk("b48_borrow", {63'd0, Borrow}, 64'd0);

      run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat);
      chk("minus1_diff", Diff, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef SUB_FLAGS_EN
      chk("minus1_ovf", {63'd0, Overflow}, 64'd1);
`endif
      run_one(64'h1234, 64'h1234, 1'b0, lat);
      chk("eq_diff", Diff, 64'd0);
      chk("eq_borrow", {63'd0, Borrow}, 64'd0);
`ifdef SUB_FLAGS_EN
      chk("eq_zero", {63'd0, Zero}, 64'd1);
`endif
      repeat (3) @(posedge clk);
      #1;

      // Streaming: 8 random operations, out_ready low for cycles 6..8
      for (int i = 0; i < 8; i++) begin
         sa[i]   = {$urandom, $urandom};
         sbv[i]  = {$urandom, $urandom};
         sbin[i] = 1'($urandom_range(0, 1));
      end
      k = 0;
      base = npop;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 6 && c < 9);
         if (k < 8) begin
            in_valid = 1'b1; A = sa[k]; B = sbv[k]; Bin = sbin[k];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!out_ready && out_valid) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            if (c == 6) begin
               hd = Diff; hb = Borrow;
            end else begin
               chk("stall_hold_diff", Diff, hd);
               chk("stall_hold_borrow", {63'd0, Borrow}, {63'd0, hb});
            end
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) k++;
      end
      out_ready = 1'b1;
      chk("stream_count", npop - base, 8);

      // Bubbles: valid pattern must reappear four edges later
      pat = '{1, 0, 1, 0, 1};
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 5) ? (pat[c] != 0) : 1'b0;
         A = {$urandom, $urandom}; B = {$urandom, $urandom}; Bin = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         ov[c] = out_valid;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         logic e;
         e = (c >= 4 && c < 9) ? (pat[c - 4] != 0) : 1'b0;
         chk("bubble_out_valid", {63'd0, ov[c]}, {63'd0, e});
      end

      // Reset mid-flight
      for (int i = 0; i < 3; i++) begin
         A = {$urandom, $urandom} | 64'h1; B = 64'd0; Bin = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_diff", Diff, 64'd0);
      chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         chk("no_stale_out", {63'd0, out_valid}, 64'd0);
      end
      run_one({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, lat);
      chk("post_rst_lat", lat, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
